// File: rtl/sorted_list_reader.sv
// Streams the valid entries of a descending-key table snapshot one per handshake, in index order.
// Optional key-order check: define SORTED_LIST_READER_ORDER_CHK_EN to add the sticky order_err output.
module sorted_list_reader #(
  parameter  int N     = 4,
  parameter  int KEY_W = 8,
  parameter  int VAL_W = 16,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [N-1:0]       in_mask,
  input  logic [N*KEY_W-1:0] in_key,
  input  logic [N*VAL_W-1:0] in_val,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [KEY_W-1:0]   out_key,
  output logic [VAL_W-1:0]   out_val,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
`ifdef SORTED_LIST_READER_ORDER_CHK_EN
  output logic               order_err,
`endif
  output logic [7:0]         drop_cnt
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t           r_state;
  logic [N-1:0]     r_pend;
  logic [KEY_W-1:0] r_key [N];
  logic [VAL_W-1:0] r_val [N];

  logic             w_out_hs;
  logic             w_accept;
  logic [N-1:0]     w_pend_nxt;
  logic [KEY_W-1:0] w_src_key [N];
  logic [VAL_W-1:0] w_src_val [N];
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_last_nxt;

  assign w_out_hs = out_vld & out_rdy;
  assign in_rdy   = !rst && !flush && (r_state == IDLE || (w_out_hs && out_last));
  assign w_accept = in_vld & in_rdy;

  // The presented entry is derived from the *next* pend value, so outputs stay registered
  // while a freshly accepted snapshot still appears one cycle after its accept.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_pend_nxt = r_pend;
    if (flush)         w_pend_nxt = '0;
    else if (w_accept) w_pend_nxt = in_mask;
    else if (w_out_hs) w_pend_nxt = r_pend & (r_pend - N'(1));

    for (int i = 0; i < N; i++) begin
      w_src_key[i] = w_accept ? in_key[i*KEY_W +: KEY_W] : r_key[i];
      w_src_val[i] = w_accept ? in_val[i*VAL_W +: VAL_W] : r_val[i];
    end

    w_idx_nxt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_pend_nxt[i]) w_idx_nxt = IDX_W'(i);
    end
    w_last_nxt = (w_pend_nxt != '0) && ((w_pend_nxt & (w_pend_nxt - N'(1))) == '0);
  end

`ifdef SORTED_LIST_READER_ORDER_CHK_EN
  logic w_order_bad;

  always_comb begin
    w_order_bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (in_mask[i] && in_mask[j] && (in_key[i*KEY_W +: KEY_W] < in_key[j*KEY_W +: KEY_W]))
          w_order_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          order_err <= 1'b0;
    else if (w_accept && w_order_bad) order_err <= 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pend   <= '0;
      // NOTE: the snapshot registers are small and reset to a defined value, so out_key/out_val never show X.
      for (int i = 0; i < N; i++) begin
        r_key[i] <= '0;
        r_val[i] <= '0;
      end
      drop_cnt <= '0;
      out_vld  <= 1'b0;
      out_key  <= '0;
      out_val  <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_pend  <= w_pend_nxt;
      r_state <= (w_pend_nxt != '0) ? DRAIN : IDLE;

      if (w_accept) begin
        for (int i = 0; i < N; i++) begin
          r_key[i] <= in_key[i*KEY_W +: KEY_W];
          r_val[i] <= in_val[i*VAL_W +: VAL_W];
        end
      end

      if (w_accept && (in_mask == '0) && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;

      out_vld <= (w_pend_nxt != '0);
      if (w_pend_nxt != '0) begin
        out_idx  <= w_idx_nxt;
        out_key  <= w_src_key[w_idx_nxt];
        out_val  <= w_src_val[w_idx_nxt];
        out_last <= w_last_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sorted_list_reader.sv
// Self-checking bench for sorted_list_reader: a cycle table plus stall/flush, async reset and order-check sequences.
module tb_sorted_list_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_vld;
  logic        in_rdy;
  logic [3:0]  in_mask;
  logic [31:0] in_key;
  logic [63:0] in_val;
  logic        out_vld;
  logic        out_rdy;
  logic [7:0]  out_key;
  logic [15:0] out_val;
  logic [1:0]  out_idx;
  logic        out_last;
  logic [7:0]  drop_cnt;
`ifdef SORTED_LIST_READER_ORDER_CHK_EN
  logic        order_err;
`endif

  sorted_list_reader #(.N(4), .KEY_W(8), .VAL_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_mask  (in_mask),
    .in_key   (in_key),
    .in_val   (in_val),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_key  (out_key),
    .out_val  (out_val),
    .out_idx  (out_idx),
    .out_last (out_last),
`ifdef SORTED_LIST_READER_ORDER_CHK_EN
    .order_err(order_err),
`endif
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        flush;
    logic        vld;
    logic [3:0]  mask;
    logic [31:0] keys;
    logic [63:0] vals;
    logic        rdy;
    logic        e_in_rdy;
    logic        e_vld;
    logic [7:0]  e_key;
    logic [15:0] e_val;
    logic [1:0]  e_idx;
    logic        e_last;
    logic [7:0]  e_drop;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic vl, input logic [3:0] m,
                              input logic [31:0] k, input logic [63:0] v, input logic rd,
                              input logic er, input logic ev, input logic [7:0] ek,
                              input logic [15:0] eval, input logic [1:0] ei, input logic el,
                              input logic [7:0] ed);
    vec_t t;
    t = '{fl, vl, m, k, v, rd, er, ev, ek, eval, ei, el, ed};
    return t;
  endfunction

  localparam logic [31:0] KA = {8'd1, 8'd4, 8'd7, 8'd9};
  localparam logic [63:0] VA = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
  localparam logic [31:0] KB = {8'd5, 8'd10, 8'd15, 8'd20};
  localparam logic [63:0] VB = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
  localparam logic [31:0] KC = {8'd0, 8'd0, 8'd25, 8'd30};
  localparam logic [63:0] VC = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
  localparam logic [31:0] KD = {8'd0, 8'd0, 8'd0, 8'd40};
  localparam logic [63:0] VD = {16'hD003, 16'hD002, 16'hD001, 16'hD000};

  vec_t tbl [18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic vl, input logic [3:0] m,
                       input logic [31:0] k, input logic [63:0] v, input logic rd);
    flush   = fl;
    in_vld  = vl;
    in_mask = m;
    in_key  = k;
    in_val  = v;
    out_rdy = rd;
  endtask

  initial begin
    //           fl vl mask     keys vals rdy | in_rdy vld key  val       idx last drop
    tbl[0]  = mk(0, 1, 4'b1111, KA, VA, 1,      1,     0,  0,   16'h0,    0,  0,   0);
    tbl[1]  = mk(0, 0, 4'b0000, 0,  0,  1,      0,     1,  9,   16'hA000, 0,  0,   0);
    tbl[2]  = mk(0, 0, 4'b0000, 0,  0,  1,      0,     1,  7,   16'hA001, 1,  0,   0);
    tbl[3]  = mk(0, 0, 4'b0000, 0,  0,  1,      0,     1,  4,   16'hA002, 2,  0,   0);
    tbl[4]  = mk(0, 0, 4'b0000, 0,  0,  1,      1,     1,  1,   16'hA003, 3,  1,   0);
    tbl[5]  = mk(0, 1, 4'b1011, KB, VB, 1,      1,     0,  0,   16'h0,    0,  0,   0);
    tbl[6]  = mk(0, 0, 4'b0000, 0,  0,  1,      0,     1,  20,  16'hB000, 0,  0,   0);
    tbl[7]  = mk(0, 0, 4'b0000, 0,  0,  1,      0,     1,  15,  16'hB001, 1,  0,   0);
    tbl[8]  = mk(0, 0, 4'b0000, 0,  0,  1,      1,     1,  5,   16'hB003, 3,  1,   0);
    tbl[9]  = mk(0, 1, 4'b0000, KA, VA, 1,      1,     0,  0,   16'h0,    0,  0,   0);
    tbl[10] = mk(0, 1, 4'b0000, KA, VA, 1,      1,     0,  0,   16'h0,    0,  0,   1);
    tbl[11] = mk(0, 1, 4'b0000, KA, VA, 1,      1,     0,  0,   16'h0,    0,  0,   2);
    tbl[12] = mk(0, 0, 4'b0000, 0,  0,  1,      1,     0,  0,   16'h0,    0,  0,   3);
    tbl[13] = mk(0, 1, 4'b0011, KC, VC, 1,      1,     0,  0,   16'h0,    0,  0,   3);
    tbl[14] = mk(0, 1, 4'b0001, KD, VD, 1,      0,     1,  30,  16'hC000, 0,  0,   3);
    tbl[15] = mk(0, 1, 4'b0001, KD, VD, 1,      1,     1,  25,  16'hC001, 1,  1,   3);
    tbl[16] = mk(0, 0, 4'b0000, 0,  0,  1,      1,     1,  40,  16'hD000, 0,  1,   3);
    tbl[17] = mk(0, 0, 4'b0000, 0,  0,  1,      1,     0,  0,   16'h0,    0,  0,   3);

    rst = 1'b1;
    drive(0, 0, 4'b0000, 0, 0, 0);
    #1;
    check("rst_out_vld",  out_vld,  0);
    check("rst_out_key",  out_key,  0);
    check("rst_out_val",  out_val,  0);
    check("rst_out_idx",  out_idx,  0);
    check("rst_out_last", out_last, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_in_rdy",   in_rdy,   0);
`ifdef SORTED_LIST_READER_ORDER_CHK_EN
    check("rst_order_err", order_err, 0);
`endif
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].flush, tbl[i].vld, tbl[i].mask, tbl[i].keys, tbl[i].vals, tbl[i].rdy);
      #1;
      check($sformatf("v%0d_in_rdy", i),   in_rdy,   tbl[i].e_in_rdy);
      check($sformatf("v%0d_out_vld", i),  out_vld,  tbl[i].e_vld);
      check($sformatf("v%0d_drop_cnt", i), drop_cnt, tbl[i].e_drop);
      if (tbl[i].e_vld) begin
        check($sformatf("v%0d_out_key", i),  out_key,  tbl[i].e_key);
        check($sformatf("v%0d_out_val", i),  out_val,  tbl[i].e_val);
        check($sformatf("v%0d_out_idx", i),  out_idx,  tbl[i].e_idx);
        check($sformatf("v%0d_out_last", i), out_last, tbl[i].e_last);
      end
      step();
    end

    // Stall mid-drain, then flush while stalled.
    drive(0, 1, 4'b1111, KA, VA, 1);
    #1;
    check("stall_accept_rdy", in_rdy, 1);
    step();
    drive(0, 0, 4'b0000, 0, 0, 1);
    step();
    out_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("stall%0d_vld", c), out_vld, 1);
      check($sformatf("stall%0d_key", c), out_key, 7);
      check($sformatf("stall%0d_val", c), out_val, 16'hA001);
      check($sformatf("stall%0d_idx", c), out_idx, 1);
      check($sformatf("stall%0d_last", c), out_last, 0);
      step();
    end
    drive(1, 1, 4'b0000, KA, VA, 0);
    #1;
    check("flush_in_rdy", in_rdy, 0);
    step();
    drive(0, 0, 4'b0000, 0, 0, 1);
    #1;
    check("post_flush_vld",    out_vld,  0);
    check("post_flush_in_rdy", in_rdy,   1);
    check("post_flush_drop",   drop_cnt, 3);
    step();

    // Asynchronous reset in the middle of a drain, away from any clock edge.
    drive(0, 1, 4'b1111, KA, VA, 1);
    step();
    drive(0, 0, 4'b0000, 0, 0, 1);
    step();
    check("pre_rst_vld", out_vld, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_vld",  out_vld,  0);
    check("arst_drop_cnt", drop_cnt, 0);
    check("arst_in_rdy",   in_rdy,   0);
    check("arst_out_key",  out_key,  0);
    step();
    rst = 1'b0;
    #1;
    check("arst_release_vld", out_vld, 0);
    check("arst_release_rdy", in_rdy,  1);
    step();

`ifdef SORTED_LIST_READER_ORDER_CHK_EN
    check("oc_before", order_err, 0);
    drive(0, 1, 4'b0011, {8'd0, 8'd0, 8'd8, 8'd3}, VA, 1);
    step();
    drive(0, 0, 4'b0000, 0, 0, 1);
    #1;
    check("oc_set",      order_err, 1);
    check("oc_drain0_k", out_key,   3);
    step();
    check("oc_drain1_k", out_key,   8);
    check("oc_drain1_l", out_last,  1);
    step();
    drive(0, 1, 4'b0011, {8'd0, 8'd0, 8'd3, 8'd8}, VA, 1);
    step();
    drive(0, 0, 4'b0000, 0, 0, 1);
    step();
    step();
    check("oc_sticky", order_err, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
